hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
- Sequencer and owner of the HI/LO architectural registers in EX.
- Accepts the eight HI/LO-class ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Launches the iterative multiplier/divider units on sign-magnitude operands, waits for done, applies sign correction and commits HI/LO.
- Stalls the pipeline while a HI/LO hazard exists; discards results of flushed operations.

Parameters:
- DIV0_COMMIT, 0: 1 = divide-by-zero still commits unit output; 0 = HI/LO left unchanged, no unit launched.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  HI/LO-class op present in EX this cycle
- op  in  3  hilo_op_t encoding
- src_a  in  32  rs value
- src_b  in  32  rt value
- flush  in  1  exception/ERET flush; kills the current op and any in-flight op
- stall  out  1  hold EX and earlier stages
- busy  out  1  unit operation in flight (MUL_WAIT, DIV_WAIT, DRAIN)
- mf_data  out  32  HI (MFHI) or LO (MFLO), combinational from registers
- hi  out  32  HI register
- lo  out  32  LO register
- mul_start  out  1  one-cycle launch pulse
- mul_a  out  32  |a| magnitude
- mul_b  out  32  |b| magnitude
- mul_done  in  1  one-cycle, mul_res valid
- mul_res  in  64  unsigned product
- div_start  out  1  one-cycle launch pulse
- div_dividend  out  32  |a| magnitude
- div_divisor  out  32  |b| magnitude
- div_done  in  1  one-cycle, quotient/remainder valid
- div_quotient  in  32  unsigned quotient
- div_remainder  in  32  unsigned remainder

Behaviour:
- Reset: state IDLE; hi=lo=0; stall=busy=0; mul_start=div_start=0; operand outputs 0; sign flags 0.
- States and transitions:
  - IDLE -> MUL_WAIT: MULT/MULTU accepted.
  - IDLE -> DIV_WAIT: DIV/DIVU accepted with divisor != 0.
  - MUL_WAIT/DIV_WAIT -> IDLE: on matching done.
  - MUL_WAIT/DIV_WAIT -> DRAIN: on flush.
  - DRAIN -> IDLE: on mul_done | div_done.
- Accept (IDLE, op_valid, !flush):
  - Operands latched as magnitudes; signed ops only: negate if bit31 set.
  - Latched sign flags: res_sign = a31^b31; rem_sign = a31. Both 0 for MULTU/DIVU.
  - The accepting MULT/DIV does not stall.
- Launch: mul_start/div_start is registered, high for exactly the first cycle in MUL_WAIT/DIV_WAIT; operand outputs held stable until done.
- Mul commit, edge after mul_done: {hi,lo} <= res_sign ? -mul_res (64-bit two's complement) : mul_res. Latency = unit latency + 1.
- Div commit: lo <= res_sign ? -quotient : quotient; hi <= rem_sign ? -remainder : remainder.
- Divide by zero:
  - DIV0_COMMIT=0: stay IDLE, no start, HI/LO unchanged.
  - DIV0_COMMIT=1: launch normally.
- MTHI/MTLO in IDLE: hi or lo <= src_a at the next edge, no stall.
- MFHI/MFLO in IDLE: mf_data valid the same cycle.
- stall = op_valid & !flush & (state==MUL_WAIT | state==DIV_WAIT), for any op. In DRAIN, stall only for MULT/MULTU/DIV/DIVU; MF*/MT* proceed because HI/LO are stable.
- Back-to-back: an op stalled on a commit cycle proceeds the next cycle (state IDLE) and sees the committed HI/LO.
- Flush:
  - op_valid with flush: op ignored, no state change.
  - Flush in IDLE or DRAIN: no effect.
  - DRAIN discards the unit output; HI/LO unchanged.
- Done pulse arriving in IDLE: ignored.
- mul_done and div_done never overlap; if both arrive, only the one matching the state is honoured.

Decomposition:
- Package hilo_pkg:
  - hilo_op_t (3-bit: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7).
  - hilo_state_t (IDLE, MUL_WAIT, DIV_WAIT, DRAIN).
  - is_muldiv() helper function.
- One natural sub-module: hilo_sign_fix, combinational magnitude-in / signed-out correction for both 64-bit product and quotient/remainder.
- FSM and HI/LO registers stay in the top.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3; unit returns 6 -> mul_a=2, mul_b=3, one-cycle start; after done {hi,lo}=0xFFFFFFFF_FFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2; unit returns q=3, r=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MFHI issued the cycle after MULT acceptance -> stall high through mul_done cycle; next cycle mf_data equals new HI.
- flush during DIV_WAIT, then MTLO 0x1234 -> MTLO not stalled, lo=0x1234; then DIVU stalls until late div_done; discarded result leaves lo=0x1234.
- DIV with b=0, DIV0_COMMIT=0 -> div_start never asserted, state IDLE, hi/lo unchanged.
- rst asserted mid MUL_WAIT -> next cycle hi=lo=0, busy=0; stray mul_done afterwards ignored.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } hilo_op_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DRAIN    = 2'd3
  } hilo_state_t;

  function automatic logic is_muldiv(input hilo_op_t op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_signed_op(input hilo_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic [31:0] negate_if32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_sign_fix.sv
// Turns unsigned unit results back into signed HI/LO values using the
// sign flags latched at launch.
module hilo_sign_fix
  import hilo_pkg::*;
(
  input  logic        i_res_sign,
  input  logic        i_rem_sign,
  input  logic [63:0] i_prod_mag,
  input  logic [31:0] i_quot_mag,
  input  logic [31:0] i_rem_mag,
  output logic [63:0] o_prod,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  assign o_prod = i_res_sign ? (~i_prod_mag + 64'd1) : i_prod_mag;
  assign o_quot = negate_if32(i_quot_mag, i_res_sign);
  assign o_rem  = negate_if32(i_rem_mag, i_rem_sign);

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner in EX: launches the iterative mul/div units on magnitudes,
// stalls on HI/LO hazards and commits sign-corrected results.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter bit DIV0_COMMIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_res,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  hilo_state_t r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_res_sign;
  logic        r_rem_sign;
  logic        r_mul_start;
  logic        r_div_start;

  hilo_op_t    w_op;
  logic        w_live;
  logic        w_is_md;
  logic        w_is_mul;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_div0;
  logic        w_launch;
  logic        w_unit_wait;
  logic        w_mt_ok;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_op        = hilo_op_t'(op);
  assign w_live      = op_valid & ~flush;
  assign w_is_md     = is_muldiv(w_op);
  assign w_is_mul    = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_a_neg     = is_signed_op(w_op) & src_a[31];
  assign w_b_neg     = is_signed_op(w_op) & src_b[31];
  assign w_div0      = ((w_op == OP_DIV) || (w_op == OP_DIVU)) && (src_b == 32'd0);
  assign w_launch    = w_live && (r_state == S_IDLE) && w_is_md &&
                       !(w_div0 && (DIV0_COMMIT == 1'b0));
  assign w_unit_wait = (r_state == S_MUL_WAIT) || (r_state == S_DIV_WAIT);
  // HI/LO are stable in DRAIN, so moves to/from them may proceed there.
  assign w_mt_ok     = w_live && ((r_state == S_IDLE) || (r_state == S_DRAIN));

  assign stall        = w_live & (w_unit_wait | ((r_state == S_DRAIN) & w_is_md));
  assign busy         = (r_state != S_IDLE);
  assign mf_data      = (w_op == OP_MFHI) ? r_hi : r_lo;
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign mul_start    = r_mul_start;
  assign mul_a        = r_a;
  assign mul_b        = r_b;
  assign div_start    = r_div_start;
  assign div_dividend = r_a;
  assign div_divisor  = r_b;

  hilo_sign_fix u_sign_fix (
    .i_res_sign (r_res_sign),
    .i_rem_sign (r_rem_sign),
    .i_prod_mag (mul_res),
    .i_quot_mag (div_quotient),
    .i_rem_mag  (div_remainder),
    .o_prod     (w_prod),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // Sequencer FSM, operand/sign latches and HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_res_sign  <= 1'b0;
      r_rem_sign  <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_a        <= negate_if32(src_a, w_a_neg);
            r_b        <= negate_if32(src_b, w_b_neg);
            r_res_sign <= w_a_neg ^ w_b_neg;
            r_rem_sign <= w_a_neg;
            if (w_is_mul) begin
              r_mul_start <= 1'b1;
              r_state     <= S_MUL_WAIT;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= S_DIV_WAIT;
            end
          end
        end
        // A done coinciding with flush is discarded without needing DRAIN.
        S_MUL_WAIT: begin
          if (flush) begin
            r_state <= mul_done ? S_IDLE : S_DRAIN;
          end else if (mul_done) begin
            {r_hi, r_lo} <= w_prod;
            r_state      <= S_IDLE;
          end
        end
        S_DIV_WAIT: begin
          if (flush) begin
            r_state <= div_done ? S_IDLE : S_DRAIN;
          end else if (div_done) begin
            r_lo    <= w_quot;
            r_hi    <= w_rem;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mul_done || div_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_mt_ok && (w_op == OP_MTHI)) begin
        r_hi <= src_a;
      end
      if (w_mt_ok && (w_op == OP_MTLO)) begin
        r_lo <= src_a;
      end
    end
  end

endmodule
